regfile_mp: RTL and testbench

Parametrised multi-port register file; successor to the single-write, two-read CPU register file. Sits in the decode stage of the pipelined/dual-issue datapath. Provides NUM_RD asynchronous read ports and two write ports with fixed priority, a hardwired zero register, and a sequenced synchronous clear with a busy handshake.

---
 rtl/regfile_mp.sv | 128 ++++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, NUM_RD async reads
// and a sequenced clear sweep with busy. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wen0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       wen1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                    state_r;
  logic [ADDR_W-1:0]         ptr_r;
  logic                      busy_r;
  logic [DATA_W-1:0]         mem_r [DEPTH];
  logic                      we0_s;
  logic                      we1_s;
  logic [ADDR_W-1:0]         rd_addr_s;
  logic [DATA_W-1:0]         rd_val_s;
  logic [NUM_RD*DATA_W-1:0]  rdata_s;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_ZERO);
  endfunction

  // Effective write enables: dropped during the sweep and for the hardwired zero entry
  always_comb begin
    we0_s = wen0 && !busy_r && !is_zero_reg(waddr0);
    we1_s = wen1 && !busy_r && !is_zero_reg(waddr1);
  end

  // Storage array: reset, sweep clear, or port writes (port 1 assigned last so it wins)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= '0;
    end else begin
      if (we0_s) begin
        mem_r[waddr0] <= wdata0;
      end
      if (we1_s) begin
        mem_r[waddr1] <= wdata1;
      end
    end
  end

  // Clear sequencer with registered busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= ADDR_ZERO;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clr_req) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
          ptr_r <= ADDR_ZERO;
        end
        ST_CLEAR: begin
          if (ptr_r == PTR_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ptr_r   <= ADDR_ZERO;
          end else begin
            ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ptr_r   <= ADDR_ZERO;
        end
      endcase
    end
  end

  // Combinational read ports, optional forwarding from this cycle's effective writes
  always_comb begin
    rdata_s   = '0;
    rd_addr_s = ADDR_ZERO;
    rd_val_s  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr_s = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      if (we1_s && (waddr1 == rd_addr_s)) begin
        rd_val_s = wdata1;
      end else if (we0_s && (waddr0 == rd_addr_s)) begin
        rd_val_s = wdata0;
      end else begin
        rd_val_s = mem_r[rd_addr_s];
      end
`else
      rd_val_s = mem_r[rd_addr_s];
`endif
      rdata_s[k*DATA_W +: DATA_W] = is_zero_reg(rd_addr_s) ? {DATA_W{1'b0}} : rd_val_s;
    end
  end

  assign rdata = rdata_s;
  assign busy  = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations per cycle, a monitor
// process pops and compares them at the falling edge.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              wen0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              wen1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic              clr_req;
  logic              busy;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            q_cyc  [$];
  int            q_port [$];
  logic [DW-1:0] q_val  [$];
  string         q_name [$];
  int            checks   = 0;
  int            failures = 0;
  bit            done     = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] v, input string nm);
    raddr[p*AW +: AW] = a;
    q_cyc.push_back(cyc);
    q_port.push_back(p);
    q_val.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic exp_busy(input logic b, input string nm);
    q_cyc.push_back(cyc);
    q_port.push_back(-1);
    q_val.push_back({{(DW-1){1'b0}}, b});
    q_name.push_back(nm);
  endtask

  task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    wen0 = e0; waddr0 = a0; wdata0 = d0;
    wen1 = e1; waddr1 = a1; wdata1 = d1;
  endtask

  // Monitor: compare every expectation whose cycle has been reached
  initial begin
    int            p;
    logic [DW-1:0] e;
    logic [DW-1:0] act;
    string         nm;
    while (!done) begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        void'(q_cyc.pop_front());
        p  = q_port.pop_front();
        e  = q_val.pop_front();
        nm = q_name.pop_front();
        if (p < 0) act = {{(DW-1){1'b0}}, busy};
        else       act = rdata[p*DW +: DW];
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s (cycle %0d): actual=%h required=%h", nm, cyc, act, e);
        end
      end
    end
    checks++;
    if (q_cyc.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: actual=%0d pending required=0", q_cyc.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1; clr_req = 1'b0; raddr = '0;
    wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    exp_busy(1'b0, "busy_in_reset");
    exp_rd(0, 5'd3, 32'h0, "rd_in_reset");
    step();
    reset = 1'b0;

    // Reset contents, single write/read
    for (int a = 0; a < DEPTH; a += NR) begin
      step();
      for (int p = 0; p < NR; p++) exp_rd(p, AW'(a + p), 32'h0, "rd_after_reset");
      exp_busy(1'b0, "busy_idle");
    end
    step(); wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd5, BYP ? 32'hDEADBEEF : 32'h0, "r5_same_cycle");
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd5, 32'hDEADBEEF, "r5_write");

    // Same-address priority, zero register, independent dual write
    step(); wr(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
    exp_rd(1, 5'd7, BYP ? 32'h22222222 : 32'h0, "r7_same_cycle");
    step(); wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    exp_rd(1, 5'd7, 32'h22222222, "r7_port1_wins");
    exp_rd(2, 5'd0, 32'h0, "r0_same_cycle");
    step(); wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55555555);
    exp_rd(2, 5'd0, 32'h0, "r0_port0_dropped");
    step(); wr(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 5'd11, 32'h0B0B0B0B);
    exp_rd(2, 5'd0, 32'h0, "r0_port1_dropped");
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd10, 32'h0A0A0A0A, "r10_port0");
    exp_rd(1, 5'd11, 32'h0B0B0B0B, "r11_port1");

    // Four read ports in parallel
    step(); wr(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step(); wr(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int p = 0; p < NR; p++) exp_rd(p, AW'(p + 1), DW'(p + 1), "multi_read");

    // Fill, then full sweep
    for (int a = 1; a < DEPTH; a += 2) begin
      step();
      wr(1'b1, AW'(a), DW'(32'hC0000000 | a), (a + 1 < DEPTH), AW'(a + 1), DW'(32'hC0000000 | (a + 1)));
    end
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    clr_req = 1'b1;
    exp_busy(1'b0, "busy_before_sweep");
    exp_rd(0, 5'd20, 32'hC0000014, "r20_filled");
    for (int c = 1; c <= DEPTH + 1; c++) begin
      step();
      clr_req = 1'b0;
      wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      exp_busy((c <= DEPTH) ? 1'b1 : 1'b0, "busy_sweep");
      if (c == 5) begin
        wr(1'b1, 5'd20, 32'h0000AAAA, 1'b0, 5'd0, 32'h0);
        exp_rd(1, 5'd20, 32'hC0000014, "r20_write_during_sweep");
      end
      if (c == 10) exp_rd(0, 5'd20, 32'hC0000014, "r20_cycle10");
      if (c == 21) exp_rd(0, 5'd20, 32'hC0000014, "r20_before_swept");
      if (c == 22) exp_rd(0, 5'd20, 32'h0, "r20_swept");
      if (c == DEPTH) begin
        exp_rd(2, 5'd31, 32'hC000001F, "r31_last_cycle");
        exp_rd(3, 5'd30, 32'h0, "r30_swept");
      end
    end
    for (int a = 0; a < DEPTH; a += NR) begin
      step();
      for (int p = 0; p < NR; p++) exp_rd(p, AW'(a + p), 32'h0, "rd_after_sweep");
    end
    step(); wr(1'b1, 5'd20, 32'h0000AAAA, 1'b0, 5'd0, 32'h0);
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd20, 32'h0000AAAA, "r20_write_after_sweep");

    // Reset mid-sweep
    step(); wr(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd31, 32'h31313131);
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    clr_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      clr_req = (c == 3);
      exp_busy(1'b1, "busy_before_reset");
      if (c == 4) exp_rd(0, 5'd3, 32'h33333333, "r3_before_reset");
    end
    step();
    clr_req = 1'b0;
    reset = 1'b1;
    exp_busy(1'b0, "busy_async_reset");
    exp_rd(0, 5'd3, 32'h0, "r3_async_reset");
    exp_rd(1, 5'd31, 32'h0, "r31_async_reset");
    step();
    reset = 1'b0;
    exp_busy(1'b0, "busy_after_reset");
    exp_rd(2, 5'd20, 32'h0, "r20_after_reset");

    // Sweep length with clr_req mid-sweep and held across the end
    step();
    clr_req = 1'b1;
    exp_busy(1'b0, "busy_idle_req");
    for (int c = 1; c <= 2 * DEPTH + 2; c++) begin
      step();
      clr_req = (c == 10) || (c >= 30 && c <= 33);
      exp_busy(((c <= DEPTH) || (c >= DEPTH + 2 && c <= 2 * DEPTH + 1)) ? 1'b1 : 1'b0, "busy_len");
    end
    clr_req = 1'b0;

    // Same-cycle read of a write
    step(); wr(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd9, BYP ? 32'h12345678 : 32'h0, "r9_same_cycle");
    step(); wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_rd(0, 5'd9, 32'h12345678, "r9_next_cycle");

    step();
    done = 1'b1;
  end

endmodule
